// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the BRAM access controller.
package mem_ctrl_pkg;

    localparam int BYTE_W = 8;

    // Controller states: idle, memory read, data capture, memory write, response.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAPT = 3'd2,
        WR   = 3'd3,
        RSP  = 3'd4
    } mem_state_t;

endpackage

// File: rtl/mem_byte_merge.sv
// Byte-lane merge: each byte comes from new_data where its enable is set,
// otherwise from old_data. Used to build the read-modify-write word.
module mem_byte_merge
    import mem_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BE_W       = DATA_WIDTH / BYTE_W
) (
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic [BE_W-1:0]       be,
    output logic [DATA_WIDTH-1:0] merged
);

    // Start from the old word and overwrite the enabled lanes.
    always_comb begin
        merged = old_data;
        for (int k = 0; k < BE_W; k++) begin
            if (be[k]) begin
                merged[k*BYTE_W +: BYTE_W] = new_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response master for a single-port BRAM with active-low strobes and
// a one-cycle registered read. Partial writes are done as read-modify-write.
//
// Handshakes: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. A valid, once raised, holds its
// payload stable until the transfer. Only one request is in flight.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter  int WORDS      = 6,
    parameter  int DATA_WIDTH = 32,
    localparam int BE_W       = DATA_WIDTH / BYTE_W
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [WORDS-1:0]      req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [BE_W-1:0]       req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [WORDS-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  mem_wr_no,
    output logic                  mem_rd_no,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    output mem_state_t            dbg_state_o
);

    mem_state_t            state_q, state_d;
    logic                  accept;
    logic                  we_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [WORDS-1:0]      addr_q;
    logic [DATA_WIDTH-1:0] wbuf_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] merged;
    logic                  ready_q;
    logic                  rsp_valid_q;
    logic                  rd_n_q;
    logic                  wr_n_q;

    assign accept      = req_valid_i & req_ready_o;
    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign mem_addr_o  = addr_q;
    assign mem_data_o  = wbuf_q;
    assign mem_rd_no   = rd_n_q;
    assign mem_wr_no   = wr_n_q;
    assign dbg_state_o = state_q;

    mem_byte_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .new_data(wdata_q),
        .old_data(mem_data_i),
        .be      (be_q),
        .merged  (merged)
    );

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: choose the access path from the request type and enables.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!req_we_i) begin
                        state_d = RD;
                    end else if (req_be_i == {BE_W{1'b1}}) begin
                        state_d = WR;
                    end else if (req_be_i == '0) begin
                        state_d = RSP;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = CAPT;
            CAPT:    state_d = we_q ? WR : RSP;
            WR:      state_d = RSP;
            RSP:     state_d = rsp_ready_i ? IDLE : RSP;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so each is valid for
    // exactly the cycle its state occupies.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
        end else begin
            ready_q     <= (state_d == IDLE);
            rsp_valid_q <= (state_d == RSP);
            rd_n_q      <= (state_d != RD);
            wr_n_q      <= (state_d != WR);
        end
    end

    // Request latches, write buffer and read-data register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                be_q    <= req_be_i;
                wdata_q <= req_wdata_i;
                addr_q  <= req_addr_i;
                // Write responses carry zero data.
                rdata_q <= '0;
                if (req_we_i) begin
                    wbuf_q <= req_wdata_i;
                end
            end
            if (state_q == CAPT) begin
                if (we_q) begin
                    wbuf_q <= merged;
                end else begin
                    rdata_q <= mem_data_i;
                end
            end
        end
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Request/response master that drives the single-port BRAM word memory (active-low `wr`/`rd` strobes, one-cycle registered read) on behalf of a CPU or loader. It accepts word reads and byte-enabled writes over a valid/ready handshake. Partial writes become a read-modify-write because the memory has no byte lanes. It sits between the core's load/store unit and the memory instance.

## Interface
- `WORDS`, 6: address width in bits; the memory holds 2^WORDS words.
- `DATA_WIDTH`, 32: word width; must be a multiple of 8. `BE_W = DATA_WIDTH/8`.
- `clk_i` in 1: clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted on `req_valid_i & req_ready_o`.
- `req_we_i` in 1: 1 = write, 0 = read.
- `req_addr_i` in WORDS: word address.
- `req_wdata_i` in DATA_WIDTH: write data.
- `req_be_i` in BE_W: byte enables; bit k covers bits [8k+7:8k]. Ignored on reads.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed on `rsp_valid_o & rsp_ready_i`.
- `rsp_rdata_o` out DATA_WIDTH: read data. 0 for write responses.
- `mem_addr_o` out WORDS: to the memory address input.
- `mem_data_o` out DATA_WIDTH: to the memory data input.
- `mem_wr_no` out 1: memory write strobe, active low.
- `mem_rd_no` out 1: memory read strobe, active low.
- `mem_data_i` in DATA_WIDTH: from the memory data output.

## Operation
- FSM states are IDLE, RD, CAPT, WR and RSP.
- In IDLE, `req_ready_o` is 1. On accept, the controller latches `we`, `addr`, `wdata` and `be`.
- Transitions leaving IDLE:
  - read: IDLE→RD→CAPT→RSP
  - write with `be` all ones: IDLE→WR→RSP
  - write with `be` = 0: IDLE→RSP; no memory access; still acknowledged.
  - any other `be`: IDLE→RD→CAPT→WR→RSP (read-modify-write).
- RD: `mem_rd_no` = 0 and `mem_addr_o` = latched address.
- CAPT: `mem_data_i` is valid.
  - Read: register it into `rsp_rdata_o`.
  - RMW: register the merge into the write buffer: byte k = `wdata` byte k if `be[k]`, else `mem_data_i` byte k.
- WR: `mem_wr_no` = 0, with `mem_addr_o` and `mem_data_o` = the write buffer.
- RSP: `rsp_valid_o` = 1. Hold until `rsp_ready_i`, then go to IDLE.
- `mem_rd_no` and `mem_wr_no` are flop outputs, low exactly during RD and WR respectively, and never low together.
- `req_ready_o` is 0 in every state except IDLE. Only one request is outstanding at a time.
- Address has no wrap or arithmetic. Address `2^WORDS-1` is a legal target.

## Timing
- Accept edge = cycle 0.
- Read: RD in cycle 1, CAPT in cycle 2, `rsp_valid_o` from cycle 3.
- Full write: `mem_wr_no` low in cycle 1, `rsp_valid_o` from cycle 2.
- Partial write: RD in cycle 1, CAPT in cycle 2, WR in cycle 3, `rsp_valid_o` from cycle 4.
- `be` = 0 write: `rsp_valid_o` from cycle 1.
- When the response handshakes in cycle N, `req_ready_o` = 1 in cycle N+1. No same-cycle response-to-accept bypass.
- Backpressure: while `rsp_valid_o` = 1 and `rsp_ready_i` = 0, `rsp_valid_o` and `rsp_rdata_o` hold stable and the memory strobes stay high.
- Reset values, applied immediately on `reset_i`:
  - state IDLE
  - `req_ready_o` = 0 while `reset_i` is high, 1 from the first cycle after release
  - `rsp_valid_o` = 0, `rsp_rdata_o` = 0
  - `mem_wr_no` = 1, `mem_rd_no` = 1
  - `mem_addr_o` = 0, `mem_data_o` = 0
- Reset mid-operation aborts with no response. If reset hits during WR, the target word is indeterminate; the bench does not check it.
- Request inputs are don't-care except on the accept edge.

## Structure
- Package `mem_ctrl_pkg`: `mem_state_t` enum (IDLE, RD, CAPT, WR, RSP) and a `BYTE_W = 8` constant.
- Sub-module `mem_byte_merge`: combinational byte-lane merge, parameterised by DATA_WIDTH. Inputs `new`, `old`, `be`; output the merged word.
- FSM, latches and strobe flops live in `mem_access_ctrl`.

## Test plan
- Reset: assert `reset_i` mid-cycle while in WR → `mem_wr_no` rises immediately and all outputs take their reset values; one cycle after release, `req_ready_o` = 1.
- Full write: addr 5, data `32'hDEADBEEF`, `be` `4'hF` → `mem_wr_no` low only in cycle 1, `rsp_valid_o` in cycle 2. A following read of addr 5 returns `32'hDEADBEEF` in cycle 3.
- RMW: starting from `mem[5]` = `32'hDEADBEEF`, write data `32'h00005A00` with `be` `4'b0010` → RD, CAPT, WR sequence. A read of addr 5 then returns `32'hDEAD5AEF`.
- Backpressure: read addr 63 with `rsp_ready_i` low for 4 cycles → `rsp_valid_o` and `rsp_rdata_o` stable, `req_ready_o` = 0, no strobes; handshake completes on cycle 5.
- `be` = 0 write to addr 7 holding `32'h12345678` → no `mem_rd_no`/`mem_wr_no` activity, response in cycle 1, and addr 7 still reads `32'h12345678`.
- Back-to-back: `rsp_ready_i` tied to 1 and 8 full writes queued → one accept every 3 cycles, the strobes never overlap, and all 8 words read back correctly.
